div_8by4_seq: RTL and testbench
===============================

DIV_8BY4_SEQ -- requirements
Module: div_8by4_seq

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only when module is in IDLE or DONE.
REQ-005 a  input  8  unsigned dividend; the operand is captured on the accepting edge.
REQ-006 b  input  4  unsigned divisor; the operand is captured on the accepting edge.
REQ-007 q  output  8  unsigned quotient, registered.
REQ-008 r  output  4  unsigned remainder, registered.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse; q/r/div_by_zero valid.
REQ-011 div_by_zero  output  1  high with done when captured b == 0 (DIV_ZERO_DETECT_EN only).

Function
REQ-012 Algorithm SHALL be restoring division, one quotient bit per cycle, MSB first, with a 5-bit partial remainder.
REQ-013 FSM states SHALL be IDLE, CALC and DONE, with a 3-bit bit counter.
REQ-014 IDLE: start=1 at edge N SHALL latch a and b, clear the partial remainder, set counter=7, enter CALC, and set busy=1.
REQ-015 CALC, each edge: rem = {rem[3:0], a_bit}; if rem >= b then rem -= b and q_bit = 1, else q_bit = 0; counter decrements.
REQ-016 The edge that processes counter==0 (edge N+8) SHALL enter DONE, update q/r, set done=1 and clear busy.
REQ-017 Latency SHALL be 8 cycles from the accepting edge to done, with a throughput of one result per 9 cycles.
REQ-018 DONE lasts exactly one cycle: with start=0 the FSM SHALL go to IDLE and drop done; with start=1 it SHALL accept new operands per REQ-014 (back-to-back).
REQ-019 start while in CALC SHALL be ignored, with no effect on operands or the result.
REQ-020 q and r SHALL hold their last result in IDLE and during CALC until the next done.
REQ-021 Results SHALL satisfy a == q*b + r and r < b for every b != 0, including a = 0, which gives q = 0 and r = 0.
REQ-022 Operand inputs changing after the accepting edge SHALL NOT affect the result.

Reset
REQ-023 rst=1 at an edge SHALL set state=IDLE, q=0, r=0, busy=0, done=0, div_by_zero=0 and counter=0.
REQ-024 Reset SHALL take priority over start in every state.
REQ-025 Reset mid-CALC SHALL abort the division, with no done pulse and q/r=0.
REQ-026 start sampled on the first edge after rst deasserts SHALL be accepted normally.

Configuration
REQ-027 Macro DIV_ZERO_DETECT_EN SHALL select divide-by-zero handling.
REQ-028 Defined: b==0 at acceptance SHALL skip CALC and enter DONE on the next edge (N+1) with q=8'hFF, r=a[3:0], div_by_zero=1, done=1, and busy high for one cycle.
REQ-029 Undefined: div_by_zero SHALL be tied 0; b==0 SHALL run the full 8-cycle CALC, giving the natural result q=8'hFF, r=a[3:0].
REQ-030 For b != 0, behaviour SHALL be identical with and without the macro.

Verification
REQ-031 a=100, b=7, start pulse -> after 8 cycles done=1 for 1 cycle, q=14, r=2, busy low in DONE.
REQ-032 a=225, b=15 -> q=15, r=0; a=195, b=15 -> q=13, r=0; a=255, b=1 -> q=255, r=0; a=0, b=9 -> q=0, r=0.
REQ-033 Back-to-back: start held high, a=90, b=9 then a=45, b=6 -> done pulses 9 cycles apart with q=10, r=0 then q=7, r=3.
REQ-034 start re-asserted mid-CALC with a=1, b=1 -> ignored; first result unchanged (100/7 -> 14 r 2).
REQ-035 Divide by zero, a=8'hA7, b=0 -> with macro: done after 1 cycle, q=255, r=7, div_by_zero=1; without macro: done after 8 cycles, q=255, r=7, div_by_zero=0.
REQ-036 rst asserted 4 cycles into CALC -> next cycle busy=0, q=0, r=0, no done; a fresh start then completes correctly.

Source files
------------

// File: rtl/div_8by4_seq_if.sv
// Operand/result bundle for the 8-by-4 sequential divider.
interface div_8by4_seq_if;
   logic       start;
   logic [7:0] a;
   logic [3:0] b;
   logic [7:0] q;
   logic [3:0] r;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   modport master (
      output start, a, b,
      input  q, r, busy, done, div_by_zero
   );

   modport slave (
      input  start, a, b,
      output q, r, busy, done, div_by_zero
   );
endinterface

// File: rtl/div_8by4_seq.sv
// 8-by-4 restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_ZERO_DETECT_EN to short-cut b==0 with a div_by_zero flag.
module div_8by4_seq (
   input logic           clk,
   input logic           rst,
   div_8by4_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t     state;
   logic [7:0] dvd;
   logic [7:0] quo;
   logic [3:0] dsr;
   logic [4:0] rem;
   logic [2:0] cnt;
   logic [7:0] q_r;
   logic [3:0] r_r;
   logic       busy_r;
   logic       done_r;
   logic       dbz_r;

   logic [4:0] rem_sh;
   logic [4:0] rem_nx;
   logic       q_bit;
   logic       zero_skip;

`ifdef DIV_ZERO_DETECT_EN
   assign zero_skip = (dsr == 4'd0);
`else
   assign zero_skip = 1'b0;
`endif

   always_comb begin
      rem_sh = {rem[3:0], dvd[7]};
      q_bit  = (rem_sh >= {1'b0, dsr});
      rem_nx = q_bit ? rem_sh - {1'b0, dsr} : rem_sh;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         dvd    <= '0;
         quo    <= '0;
         dsr    <= '0;
         rem    <= '0;
         cnt    <= '0;
         q_r    <= '0;
         r_r    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  dvd    <= bus.a;
                  dsr    <= bus.b;
                  rem    <= '0;
                  quo    <= '0;
                  cnt    <= 3'd7;
                  busy_r <= 1'b1;
                  state  <= CALC;
               end else begin
                  state  <= IDLE;
               end
            end
            CALC: begin
               if (zero_skip) begin
                  q_r    <= 8'hFF;
                  r_r    <= dvd[3:0];
                  dbz_r  <= 1'b1;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  cnt    <= 3'd0;
                  state  <= DONE;
               end else begin
                  dvd <= {dvd[6:0], 1'b0};
                  rem <= rem_nx;
                  quo <= {quo[6:0], q_bit};
                  cnt <= cnt - 3'd1;
                  // last bit: publish the result straight from the datapath
                  if (cnt == 3'd0) begin
                     q_r    <= {quo[6:0], q_bit};
                     r_r    <= rem_nx[3:0];
                     done_r <= 1'b1;
                     busy_r <= 1'b0;
                     cnt    <= 3'd0;
                     state  <= DONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.q           = q_r;
   assign bus.r           = r_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_div_8by4_seq.sv
// Scoreboard bench for div_8by4_seq: arithmetic reference model,
// queue of expected results, monitor checking every done pulse.
module tb_div_8by4_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   div_8by4_seq_if bus();

   div_8by4_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] last_q   = '0;
   logic [3:0] last_r   = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain integer division; b==0 yields all-ones / low nibble
   function automatic exp_t model(input logic [7:0] a,
                                  input logic [3:0] b,
                                  input int now);
      exp_t e;
      int   lat;
      lat = 8;
      e.dz = 1'b0;
      if (b == 4'd0) begin
         e.q = 8'hFF;
         e.r = a[3:0];
`ifdef DIV_ZERO_DETECT_EN
         lat  = 1;
         e.dz = 1'b1;
`endif
      end else begin
         e.q = 8'(int'(a) / int'(b));
         e.r = 4'(int'(a) % int'(b));
      end
      e.cyc = now + 1 + lat;
      return e;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("q", 32'(bus.q), 32'(e.q));
            chk("r", 32'(bus.r), 32'(e.r));
            chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("busy_in_done", 32'(bus.busy), 32'd0);
            last_q = e.q;
            last_r = e.r;
         end
      end
   end

   // Called on a negedge; operands are scrambled right after acceptance
   task automatic issue(input logic [7:0] a, input logic [3:0] b);
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      sb.push_back(model(a, b, cyc));
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 8'($urandom);
      bus.b     = 4'($urandom);
      chk("busy_after_accept", 32'(bus.busy), 32'd1);
      chk("q_hold", 32'(bus.q), 32'(last_q));
      chk("r_hold", 32'(bus.r), 32'(last_r));
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
      chk("drain_pending", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      int t;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_q", 32'(bus.q), 32'd0);
      chk("rst_r", 32'(bus.r), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);

      rst = 1'b0;
      issue(8'd100, 4'd7);
      wait_drain();
      issue(8'd225, 4'd15); wait_drain();
      issue(8'd195, 4'd15); wait_drain();
      issue(8'd255, 4'd1);  wait_drain();
      issue(8'd0,   4'd9);  wait_drain();
      issue(8'hA7,  4'd0);  wait_drain();

      // start mid-CALC must be ignored
      issue(8'd100, 4'd7);
      repeat (2) @(negedge clk);
      bus.a     = 8'd1;
      bus.b     = 4'd1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_drain();

      // back-to-back with start held high
      @(negedge clk);
      bus.a     = 8'd90;
      bus.b     = 4'd9;
      bus.start = 1'b1;
      t = cyc;
      sb.push_back(model(8'd90, 4'd9, t));
      @(negedge clk);
      bus.a = 8'd45;
      bus.b = 4'd6;
      repeat (8) @(negedge clk);
      sb.push_back(model(8'd45, 4'd6, cyc));
      @(negedge clk);
      bus.start = 1'b0;
      wait_drain();

      // reset four cycles into CALC
      issue(8'd200, 4'd3);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      sb.delete();
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_q", 32'(bus.q), 32'd0);
      chk("abort_r", 32'(bus.r), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      last_q = '0;
      last_r = '0;
      rst = 1'b0;
      issue(8'd77, 4'd5);
      wait_drain();

      for (int n = 0; n < 150; n++) begin
         logic [7:0] ra;
         logic [3:0] rb;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
         issue(ra, rb);
         wait_drain();
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
